// File: rtl/adc_sar_seq_ctrl.sv
// SAR conversion sequencer: drives samp, waits for eoc, checks B/BN complementarity
// and queues results in a small valid/ready FIFO with sticky timeout/overflow flags.
module adc_sar_seq_ctrl #(
  parameter int SAMP_CYCLES  = 4,
  parameter int CONV_TIMEOUT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       clr,
  output logic       samp,
  input  logic       eoc,
  input  logic [9:0] b_in,
  input  logic [9:0] bn_in,
  output logic [9:0] data_out,
  output logic       data_err,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       busy,
  output logic       timeout,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CONV_TIMEOUT + 1);
  localparam logic [3:0]    SAMP_LAST = 4'(SAMP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(CONV_TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SAMPLE, ST_CONVERT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    scnt_q, scnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          samp_q, samp_d;
  logic          timeout_q, timeout_d;
  logic          overflow_q, overflow_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [10:0]   hold_q, hold_d;
  logic [10:0]   mem_q [FIFO_DEPTH];
  logic [10:0]   head;
  logic          push_req, push, pop, full, empty, conv_timeout;

  always_comb begin
    state_d      = state_q;
    scnt_d       = scnt_q;
    tcnt_d       = tcnt_q;
    push_req     = 1'b0;
    conv_timeout = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SAMPLE;
          scnt_d  = '0;
        end
      end
      ST_SAMPLE: begin
        if (scnt_q == SAMP_LAST) begin
          state_d = ST_CONVERT;
          tcnt_d  = '0;
        end else begin
          scnt_d = scnt_q + 4'd1;
        end
      end
      ST_CONVERT: begin
        tcnt_d = tcnt_q + 1'b1;
        if (eoc) begin
          push_req = 1'b1;
          if (cont && start) begin
            state_d = ST_SAMPLE;
            scnt_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (tcnt_q == TO_LAST) begin
          conv_timeout = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    samp_d = (state_d == ST_SAMPLE);
  end

  // Wrap bit differs but index matches -> full; a pop on the same edge frees the slot.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && data_ready;
  assign push  = push_req && (!full || pop);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    timeout_d = (timeout_q && !clr) || conv_timeout;
    if (clr) begin
      overflow_d = 1'b0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = wr_ptr_q;
      hold_d     = {data_err, data_out};
    end else begin
      overflow_d = overflow_q || (push_req && full && !pop);
      wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
      rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
      hold_d     = pop ? head : hold_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      scnt_q     <= '0;
      tcnt_q     <= '0;
      samp_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      tcnt_q     <= tcnt_d;
      samp_q     <= samp_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      hold_q     <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {(b_in != ~bn_in), b_in};
    end
  end

  // An empty FIFO keeps presenting the last popped word instead of stale storage.
  assign data_out   = empty ? hold_q[9:0] : head[9:0];
  assign data_err   = empty ? hold_q[10]  : head[10];
  assign data_valid = !empty;
  assign samp       = samp_q;
  assign busy       = (state_q != ST_IDLE);
  assign timeout    = timeout_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_adc_sar_seq_ctrl.sv
// Directed bench for adc_sar_seq_ctrl: table of single conversions against a SAR
// eoc model, plus hand-written timeout, overflow, full-FIFO, clr and reset sequences.
module tb_adc_sar_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, cont, clr, eoc, data_ready;
  logic [9:0] b_in, bn_in;
  logic       samp, data_err, data_valid, busy, timeout, overflow;
  logic [9:0] data_out;

  logic eoc_model = 1'b0;
  logic eoc_force = 1'b0;
  logic sar_en    = 1'b1;
  bit   armed     = 1'b0;
  int   sar_cnt   = 0;

  int checks = 0;
  int errors = 0;

  adc_sar_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .clr(clr),
    .samp(samp), .eoc(eoc), .b_in(b_in), .bn_in(bn_in),
    .data_out(data_out), .data_err(data_err), .data_valid(data_valid),
    .data_ready(data_ready), .busy(busy), .timeout(timeout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  assign eoc = eoc_model | eoc_force;

  // SAR model: eoc high during the 11th clock after samp falls.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     = 1'b0;
      eoc_model = 1'b0;
    end else begin
      eoc_model = 1'b0;
      if (samp) begin
        armed   = 1'b1;
        sar_cnt = 0;
      end else if (armed) begin
        sar_cnt++;
        if (sar_cnt == 11) begin
          eoc_model = sar_en;
          armed     = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [9:0] b;
    logic [9:0] bn;
    logic [9:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic run_single(input vec_t v, input int idx);
    @(negedge clk);
    b_in = v.b; bn_in = v.bn; start = 1'b1; cont = 1'b0;
    @(negedge clk);
    chk("samp_rise", {31'd0, samp}, 32'd1);
    chk("busy_rise", {31'd0, busy}, 32'd1);
    start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      chk("samp_window", {31'd0, samp}, {31'd0, (i <= 3)});
      chk("valid_timing", {31'd0, data_valid}, {31'd0, (i == 15)});
    end
    chk("single_data", {22'd0, data_out}, {22'd0, v.exp_data});
    chk("single_err", {31'd0, data_err}, {31'd0, v.exp_err});
    chk("single_busy_low", {31'd0, busy}, 32'd0);
    $display("vec %0d: b=%h bn=%h -> data_out=%h data_err=%b", idx, v.b, v.bn, data_out, data_err);
    data_ready = 1'b1;
    @(negedge clk);
    chk("single_popped", {31'd0, data_valid}, 32'd0);
    chk("single_hold", {22'd0, data_out}, {22'd0, v.exp_data});
    data_ready = 1'b0;
  endtask

  logic [9:0] cv[6];
  logic [9:0] fv[5];
  int pops;

  initial begin
    vecs[0] = '{10'h2A5, 10'h15A, 10'h2A5, 1'b0};
    vecs[1] = '{10'h3FF, 10'h001, 10'h3FF, 1'b1};
    vecs[2] = '{10'h000, 10'h3FF, 10'h000, 1'b0};
    vecs[3] = '{10'h155, 10'h2AA, 10'h155, 1'b0};
    vecs[4] = '{10'h200, 10'h1FF, 10'h200, 1'b0};
    vecs[5] = '{10'h123, 10'h123, 10'h123, 1'b1};
    cv = '{10'h011, 10'h022, 10'h033, 10'h044, 10'h055, 10'h066};
    fv = '{10'h101, 10'h102, 10'h103, 10'h104, 10'h105};

    rst_n = 1'b0; start = 1'b0; cont = 1'b0; clr = 1'b0; data_ready = 1'b0;
    b_in = '0; bn_in = '0;
    wait_neg(3);
    chk("rst_samp", {31'd0, samp}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_data", {22'd0, data_out}, 32'd0);
    chk("rst_err", {31'd0, data_err}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_single(vecs[i], i);

    // eoc outside CONVERT is ignored
    @(negedge clk); eoc_force = 1'b1;
    @(negedge clk); eoc_force = 1'b0;
    chk("idle_eoc_ignored", {31'd0, data_valid}, 32'd0);

    // Timeout with SAR disconnected
    sar_en = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_neg(19);
    chk("to_not_yet", {31'd0, timeout}, 32'd0);
    chk("to_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("to_set", {31'd0, timeout}, 32'd1);
    chk("to_busy_low", {31'd0, busy}, 32'd0);
    chk("to_fifo_empty", {31'd0, data_valid}, 32'd0);
    wait_neg(3);
    chk("to_sticky", {31'd0, timeout}, 32'd1);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("to_cleared", {31'd0, timeout}, 32'd0);
    $display("timeout sequence: timeout=%b busy=%b", timeout, busy);
    sar_en = 1'b1;

    // Continuous mode, consumer stalled: six conversions into four slots
    @(negedge clk);
    b_in = cv[0]; bn_in = ~cv[0]; start = 1'b1; cont = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_neg(k == 0 ? 16 : 15);
      chk("cont_valid", {31'd0, data_valid}, 32'd1);
      chk("cont_head", {22'd0, data_out}, {22'd0, cv[0]});
      chk("cont_overflow", {31'd0, overflow}, {31'd0, (k >= 4)});
      $display("cont push %0d: head=%h overflow=%b", k, data_out, overflow);
      if (k == 4) start = 1'b0;
      if (k < 5) begin b_in = cv[k+1]; bn_in = ~cv[k+1]; end
    end
    chk("cont_idle", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", {31'd0, data_valid}, 32'd1);
      chk("drain_data", {22'd0, data_out}, {22'd0, cv[i]});
      chk("drain_err", {31'd0, data_err}, 32'd0);
      data_ready = 1'b1;
      @(negedge clk);
    end
    data_ready = 1'b0;
    chk("drain_empty", {31'd0, data_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);

    // Full FIFO: push and pop on the same edge
    @(negedge clk);
    b_in = fv[0]; bn_in = ~fv[0]; start = 1'b1; cont = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin
        wait_neg(14);
        data_ready = 1'b1;
        wait_neg(1);
        data_ready = 1'b0;
      end else begin
        wait_neg(k == 0 ? 16 : 15);
        if (k == 3) start = 1'b0;
        b_in = fv[k+1]; bn_in = ~fv[k+1];
      end
    end
    chk("fullpop_overflow", {31'd0, overflow}, 32'd0);
    chk("fullpop_idle", {31'd0, busy}, 32'd0);
    pops = 0;
    data_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (data_valid) begin
        if (pops < 4) chk("fullpop_data", {22'd0, data_out}, {22'd0, fv[pops+1]});
        pops++;
      end
      @(negedge clk);
    end
    data_ready = 1'b0;
    chk("fullpop_count", pops, 32'd4);
    $display("full fifo push+pop: entries=%0d overflow=%b", pops, overflow);

    // clr flushes a non-empty FIFO
    @(negedge clk); b_in = 10'h0F0; bn_in = 10'h30F; start = 1'b1; cont = 1'b0;
    @(negedge clk); start = 1'b0;
    wait_neg(15);
    chk("clr_pre_valid", {31'd0, data_valid}, 32'd1);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("clr_flush", {31'd0, data_valid}, 32'd0);

    // Async reset mid-SAMPLE with a queued entry
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_neg(15);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    chk("pre_rst_samp", {31'd0, samp}, 32'd1);
    chk("pre_rst_valid", {31'd0, data_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_samp", {31'd0, samp}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_mid_flags", {30'd0, timeout, overflow}, 32'd0);
    #1 rst_n = 1'b1;

    // Async reset mid-CONVERT
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_neg(7);
    chk("pre_rst_conv", {30'd0, busy, samp}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_conv_samp", {31'd0, samp}, 32'd0);
    chk("rst_conv_busy", {31'd0, busy}, 32'd0);
    #1 rst_n = 1'b1;
    wait_neg(2);
    run_single(vecs[0], 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_sar_seq_ctrl.md
# adc_sar_seq_ctrl

Conversion sequencer and result buffer placed directly beside the 10-bit SAR bit-logic block. It drives the SAR `samp` (sampling/reset) input, waits for the end-of-conversion pulse, and captures the B/BN result words. It checks that the words are complementary and queues results in a small FIFO with a valid/ready handshake toward the digital consumer (Wishbone/logic-analyser side). It also supervises conversion length and reports timeout and overflow.

## Interface
- `SAMP_CYCLES`, default 4: clocks `samp` is held high per conversion (range 1–15).
- `CONV_TIMEOUT`, default 16: max clocks in CONVERT before timeout (must be > 11).
- `FIFO_DEPTH`, default 4: result entries (power of 2, ≥ 2).
- `clk`  in  1: single clock, shared with the SAR logic.
- `rst_n`  in  1: reset, asynchronous assert, active-low.
- `start`  in  1: level; conversion request sampled in IDLE.
- `cont`  in  1: continuous mode; re-sample immediately while `start` stays high.
- `clr`  in  1: one-cycle pulse; clears sticky flags and flushes the FIFO.
- `samp`  out  1: to SAR logic Samp, registered.
- `eoc`  in  1: from SAR logic, one-clock pulse synchronous to `clk`.
- `b_in`  in  10: SAR result B[9:0].
- `bn_in`  in  10: SAR result BN[9:0].
- `data_out`  out  10: FIFO head result.
- `data_err`  out  1: FIFO head captured with B/BN mismatch.
- `data_valid`  out  1: FIFO non-empty.
- `data_ready`  in  1: consumer accepts head when `data_valid && data_ready` at a rising edge.
- `busy`  out  1: state ≠ IDLE.
- `timeout`  out  1: sticky, conversion exceeded `CONV_TIMEOUT`.
- `overflow`  out  1: sticky, result dropped because FIFO full.

## Operation
- Reset values: state IDLE; `samp`=0; `busy`=0; `data_valid`=0; `data_out`=0; `data_err`=0; `timeout`=0; `overflow`=0; FIFO empty; counters 0.
- FSM states: IDLE, SAMPLE, CONVERT.
- IDLE, `start`=1 → SAMPLE. `samp` goes 1 at the same edge, sample counter loads 0.
- SAMPLE: `samp`=1. After `SAMP_CYCLES` edges in SAMPLE → CONVERT. `samp` goes 0 at that edge; timeout counter clears.
- CONVERT: `samp`=0; timeout counter increments each clock.
  - `eoc`=1 → push {`b_in != ~bn_in`, `b_in`} into FIFO. Then → SAMPLE if `cont && start`, else → IDLE.
  - No `eoc` with counter reaching `CONV_TIMEOUT` → set `timeout`, → IDLE, no push.
- `eoc` in IDLE/SAMPLE is ignored; no push.
- `start` deasserted during SAMPLE/CONVERT does not abort; the current conversion completes.
- FIFO push when full: word dropped and `overflow` set. Push and pop at the same edge while full: both occur, no overflow.
- Pop on `data_valid && data_ready`. Empty FIFO ignores `data_ready`.
- `data_out`/`data_err` reflect the head entry combinationally from FIFO storage. They hold when the FIFO is empty (last value, or 0 after reset).
- `clr`: clears `timeout` and `overflow`, empties the FIFO. It has priority over a same-cycle push or pop, and the FSM is unaffected. A same-edge timeout still sets `timeout`.
- Sticky flags are set/held only; they are cleared only by `clr` or reset.
- Pointers are log2(FIFO_DEPTH) bits plus one wrap bit; full/empty come from the wrap-bit compare.
- Async reset mid-conversion: `samp` drops to 0 immediately and FSM returns to IDLE. The SAR state is don't-care until the next SAMPLE.

## Timing
- `start` high at edge N in IDLE: `samp`=1 from edge N through edge N+`SAMP_CYCLES`; falls at edge N+`SAMP_CYCLES`.
- SAR nominal: `eoc` high during the 11th clock after `samp` falls. Push at edge N+`SAMP_CYCLES`+11; `data_valid` high after that edge.
- Continuous mode period: `SAMP_CYCLES`+11 clocks per result (4+11 = 15 with defaults); `samp` re-rises at the push edge.
- Timeout: edge N+`SAMP_CYCLES`+`CONV_TIMEOUT`; `busy` low after it.
- Handshake: `data_valid` never depends combinationally on `data_ready`. Back-to-back pops take one entry per clock.

## Test plan
- Single conversion with SAR model, `b_in`=10'h2A5, `bn_in`=10'h15A → `samp` high 4 clocks; one entry with `data_out`=10'h2A5 and `data_err`=0 at edge start+15; `busy` low afterward.
- Mismatch: `b_in`=10'h3FF, `bn_in`=10'h001 at `eoc` → entry pushed with `data_err`=1; `data_out`=10'h3FF.
- No `eoc` (SAR disconnected) → `timeout`=1 at start+4+16, FSM IDLE, FIFO empty. `clr` pulse → `timeout`=0.
- Continuous mode, `data_ready`=0, 6 conversions → 4 entries kept (first four values in order); `overflow`=1 after the 5th. Then `data_ready`=1 → 4 pops in 4 clocks, then `data_valid`=0.
- Full FIFO with `data_ready`=1 on the same edge as `eoc` → push and pop both occur, `overflow` stays 0, count stays 4.
- `rst_n` low mid-SAMPLE and mid-CONVERT → `samp`=0 and `busy`=0 without a clock edge, FIFO empty, flags 0. Normal conversion succeeds after release.
